// File: rtl/pipe_ctrl_unit_if.sv
// Decode/execute boundary bundle of the pipeline control unit.
// master drives the IF/ID fields and the branch result; slave is the control unit.
interface pipe_ctrl_unit_if #(
  parameter int unsigned RA_W = 4
) ();
  logic            id_valid;
  logic [3:0]      id_op_code;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic [RA_W-1:0] id_rd;
  logic            ex_branch_taken;

  logic            stall;
  logic            ex_valid;
  logic [2:0]      ex_alu_op;
  logic            ex_alu_src;
  logic            ex_reg_wen;
  logic            ex_reg_dst;
  logic            ex_mem_ren;
  logic            ex_mem_wen;
  logic            ex_mem_to_reg;
  logic            ex_branch;
  logic [RA_W-1:0] ex_wr_addr;
  logic            ex_illegal;

  modport master (
    output id_valid, id_op_code, id_rs, id_rt, id_rd, ex_branch_taken,
    input  stall, ex_valid, ex_alu_op, ex_alu_src, ex_reg_wen, ex_reg_dst,
           ex_mem_ren, ex_mem_wen, ex_mem_to_reg, ex_branch, ex_wr_addr, ex_illegal
  );

  modport slave (
    input  id_valid, id_op_code, id_rs, id_rt, id_rd, ex_branch_taken,
    output stall, ex_valid, ex_alu_op, ex_alu_src, ex_reg_wen, ex_reg_dst,
           ex_mem_ren, ex_mem_wen, ex_mem_to_reg, ex_branch, ex_wr_addr, ex_illegal
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Decode-stage control unit: opcode decode into the ID/EX register, with
// load-use stall, multi-cycle MUL hold, taken-branch flush and illegal-opcode squash.
module pipe_ctrl_unit #(
  parameter int unsigned RA_W     = 4,
  parameter int unsigned MUL_LAT  = 3,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  pipe_ctrl_unit_if.slave pc
);
  localparam int unsigned CNT_W = $clog2(MUL_LAT) + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_COM = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd10;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_wen;
    logic       reg_dst;
    logic       mem_ren;
    logic       mem_wen;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  ctrl_t            dec;
  logic             legal;
  logic             uses_rt;
  logic [RA_W-1:0]  wr_dec;

  ctrl_t            ex_q;
  logic             ex_valid_q;
  logic [RA_W-1:0]  ex_wr_q;
  logic             ex_illegal_q;
  logic [CNT_W-1:0] mul_cnt;

  logic             mul_busy;
  logic             flush;
  logic             dst_live;
  logic             src_hit;
  logic             load_use;
  logic             issue;

  // Opcode decode; illegal opcodes leave the all-zero bundle.
  always_comb begin
    dec     = '0;
    legal   = 1'b1;
    uses_rt = 1'b0;
    case (pc.id_op_code)
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_MUL: begin
        dec.alu_op     = pc.id_op_code[2:0];
        dec.reg_wen    = 1'b1;
        dec.mem_to_reg = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_COM: begin
        dec.alu_op     = pc.id_op_code[2:0];
        dec.reg_wen    = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OP_SLL, OP_SRL: begin
        dec.alu_op     = pc.id_op_code[2:0];
        dec.alu_src    = 1'b1;
        dec.reg_wen    = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OP_LW: begin
        dec.alu_src = 1'b1;
        dec.reg_wen = 1'b1;
        dec.reg_dst = 1'b1;
        dec.mem_ren = 1'b1;
      end
      OP_SW: begin
        dec.alu_src    = 1'b1;
        dec.reg_dst    = 1'b1;
        dec.mem_wen    = 1'b1;
        dec.mem_to_reg = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_op     = 3'd1;
        dec.reg_dst    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.branch     = 1'b1;
        uses_rt        = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign wr_dec   = dec.reg_dst ? pc.id_rt : pc.id_rd;

  // Hazard conditions from the current EX contents and the ID instruction.
  assign mul_busy = (mul_cnt != '0);
  assign flush    = ex_valid_q & ex_q.branch & pc.ex_branch_taken;
  assign dst_live = !(ZERO_REG && (ex_wr_q == '0));
  assign src_hit  = (legal & (ex_wr_q == pc.id_rs)) | (uses_rt & (ex_wr_q == pc.id_rt));
  assign load_use = pc.id_valid & ex_valid_q & ex_q.mem_ren & dst_live & src_hit;
  assign issue    = pc.id_valid & legal;

  assign pc.stall = mul_busy | (load_use & ~flush);

  // ID/EX register: MUL hold, then flush/load-use bubble, then normal issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      ex_valid_q   <= 1'b0;
      ex_wr_q      <= '0;
      ex_illegal_q <= 1'b0;
      mul_cnt      <= '0;
    end else begin
      ex_illegal_q <= 1'b0;
      if (mul_busy) begin
        mul_cnt <= mul_cnt - CNT_W'(1);
      end else if (flush || load_use) begin
        ex_q       <= '0;
        ex_valid_q <= 1'b0;
        ex_wr_q    <= '0;
      end else begin
        ex_q         <= issue ? dec : '0;
        ex_valid_q   <= issue;
        ex_wr_q      <= issue ? wr_dec : '0;
        ex_illegal_q <= pc.id_valid & ~legal;
        if (issue && (pc.id_op_code == OP_MUL)) begin
          mul_cnt <= CNT_W'(MUL_LAT - 1);
        end
      end
    end
  end

  assign pc.ex_valid      = ex_valid_q;
  assign pc.ex_alu_op     = ex_q.alu_op;
  assign pc.ex_alu_src    = ex_q.alu_src;
  assign pc.ex_reg_wen    = ex_q.reg_wen;
  assign pc.ex_reg_dst    = ex_q.reg_dst;
  assign pc.ex_mem_ren    = ex_q.mem_ren;
  assign pc.ex_mem_wen    = ex_q.mem_wen;
  assign pc.ex_mem_to_reg = ex_q.mem_to_reg;
  assign pc.ex_branch     = ex_q.branch;
  assign pc.ex_wr_addr    = ex_wr_q;
  assign pc.ex_illegal    = ex_illegal_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: scenario tasks drive a cycle table,
// push the expected EX bundle to a scoreboard queue and compare after each edge.
module tb_pipe_ctrl_unit;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, COM = 4'd4, MUL = 4'd5;
  localparam logic [3:0] LW  = 4'd8, BEQ = 4'd10;

  typedef struct packed {
    logic       valid;
    logic [2:0] alu_op;
    logic       alu_src, reg_wen, reg_dst, mem_ren, mem_wen, mem_to_reg, branch;
    logic [3:0] wr;
    logic       illegal;
  } obs_t;

  typedef struct packed {
    logic       v;
    logic [3:0] op, rs, rt, rd;
    logic       tk;
    logic       st;
    logic       st_b;
    obs_t       e;
    obs_t       e_b;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  obs_t sb_a[$];
  obs_t sb_b[$];
  obs_t obs_a, obs_b, got;

  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.RA_W(4)) ifa ();
  pipe_ctrl_unit_if #(.RA_W(4)) ifb ();

  assign ifb.id_valid        = ifa.id_valid;
  assign ifb.id_op_code      = ifa.id_op_code;
  assign ifb.id_rs           = ifa.id_rs;
  assign ifb.id_rt           = ifa.id_rt;
  assign ifb.id_rd           = ifa.id_rd;
  assign ifb.ex_branch_taken = ifa.ex_branch_taken;

  pipe_ctrl_unit #(.RA_W(4), .MUL_LAT(3), .ZERO_REG(1'b1)) u_dut  (.clk(clk), .rst_n(rst_n), .pc(ifa));
  pipe_ctrl_unit #(.RA_W(4), .MUL_LAT(1), .ZERO_REG(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .pc(ifb));

  assign obs_a = {ifa.ex_valid, ifa.ex_alu_op, ifa.ex_alu_src, ifa.ex_reg_wen, ifa.ex_reg_dst,
                  ifa.ex_mem_ren, ifa.ex_mem_wen, ifa.ex_mem_to_reg, ifa.ex_branch,
                  ifa.ex_wr_addr, ifa.ex_illegal};
  assign obs_b = {ifb.ex_valid, ifb.ex_alu_op, ifb.ex_alu_src, ifb.ex_reg_wen, ifb.ex_reg_dst,
                  ifb.ex_mem_ren, ifb.ex_mem_wen, ifb.ex_mem_to_reg, ifb.ex_branch,
                  ifb.ex_wr_addr, ifb.ex_illegal};

  // Reference decode table for an instruction that actually issues into EX.
  function automatic obs_t exp_ex(input logic v, input logic [3:0] op, input logic [3:0] rt,
                                  input logic [3:0] rd);
    obs_t e;
    e = '0;
    if (v) begin
      e.valid = 1'b1;
      case (op)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
          e.alu_op = op[2:0]; e.reg_wen = 1'b1; e.mem_to_reg = 1'b1; e.wr = rd;
        end
        4'd6, 4'd7: begin
          e.alu_op = op[2:0]; e.alu_src = 1'b1; e.reg_wen = 1'b1; e.mem_to_reg = 1'b1; e.wr = rd;
        end
        4'd8: begin
          e.alu_src = 1'b1; e.reg_wen = 1'b1; e.reg_dst = 1'b1; e.mem_ren = 1'b1; e.wr = rt;
        end
        4'd9: begin
          e.alu_src = 1'b1; e.reg_dst = 1'b1; e.mem_wen = 1'b1; e.mem_to_reg = 1'b1; e.wr = rt;
        end
        4'd10: begin
          e.alu_op = 3'd1; e.reg_dst = 1'b1; e.mem_to_reg = 1'b1; e.branch = 1'b1; e.wr = rt;
        end
        default: begin
          e = '0;
          e.illegal = 1'b1;
        end
      endcase
    end
    return e;
  endfunction

  function automatic cyc_t mk(input logic v, input logic [3:0] op, input logic [3:0] rs,
                              input logic [3:0] rt, input logic [3:0] rd, input logic tk,
                              input logic st, input obs_t e);
    cyc_t c;
    c.v = v; c.op = op; c.rs = rs; c.rt = rt; c.rd = rd; c.tk = tk;
    c.st = st; c.st_b = st; c.e = e; c.e_b = e;
    return c;
  endfunction

  task automatic drive(input cyc_t c);
    ifa.id_valid        = c.v;
    ifa.id_op_code      = c.op;
    ifa.id_rs           = c.rs;
    ifa.id_rt           = c.rt;
    ifa.id_rd           = c.rd;
    ifa.ex_branch_taken = c.tk;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc_t c;
    drive(mk(1'b0, ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, '0));
    #10;
    checks++; if (obs_a !== obs_t'(0)) begin errors++; $display("FAIL reset_ex got %h exp %h", obs_a, obs_t'(0)); end
    checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", ifa.stall); end
    @(negedge clk); rst_n = 1'b1;
    // Issue a MUL, then assert reset while the hold count is 2.
    drive(mk(1'b1, MUL, 4'd1, 4'd2, 4'd5, 1'b0, 1'b0, '0));
    tick();
    drive(mk(1'b0, ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, '0));
    checks++; if (ifa.stall !== 1'b1) begin errors++; $display("FAIL rst_mul_stall got %b exp 1", ifa.stall); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (obs_a !== obs_t'(0)) begin errors++; $display("FAIL rst_mid_mul_ex got %h exp 0", obs_a); end
    checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL rst_mid_mul_stall got %b exp 0", ifa.stall); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL rst_release_stall got %b exp 0", ifa.stall); end
    c = mk(1'b1, ADD, 4'd1, 4'd2, 4'd7, 1'b0, 1'b0, exp_ex(1'b1, ADD, 4'd2, 4'd7));
    drive(c); sb_a.push_back(c.e);
    tick(); got = sb_a.pop_front();
    checks++; if (obs_a !== got) begin errors++; $display("FAIL rst_first_add got %h exp %h", obs_a, got); end
  endtask

  task automatic test_load_use();
    cyc_t t[$];
    t.push_back(mk(1, LW,  4'd1, 4'd3, 4'd0, 0, 0, exp_ex(1, LW,  4'd3, 4'd0)));
    t.push_back(mk(1, ADD, 4'd3, 4'd4, 4'd6, 0, 1, '0));
    t.push_back(mk(1, ADD, 4'd3, 4'd4, 4'd6, 0, 0, exp_ex(1, ADD, 4'd4, 4'd6)));
    t.push_back(mk(1, LW,  4'd1, 4'd0, 4'd0, 0, 0, exp_ex(1, LW,  4'd0, 4'd0)));
    t.push_back(mk(1, ADD, 4'd0, 4'd0, 4'd5, 0, 0, exp_ex(1, ADD, 4'd0, 4'd5)));
    t.push_back(mk(1, LW,  4'd1, 4'd4, 4'd0, 0, 0, exp_ex(1, LW,  4'd4, 4'd0)));
    t.push_back(mk(1, COM, 4'd1, 4'd4, 4'd2, 0, 0, exp_ex(1, COM, 4'd4, 4'd2)));
    foreach (t[i]) begin
      drive(t[i]); sb_a.push_back(t[i].e);
      checks++; if (ifa.stall !== t[i].st) begin errors++; $display("FAIL lu_stall[%0d] got %b exp %b", i, ifa.stall, t[i].st); end
      tick(); got = sb_a.pop_front();
      checks++; if (obs_a !== got) begin errors++; $display("FAIL lu_ex[%0d] got %h exp %h", i, obs_a, got); end
    end
  endtask

  task automatic test_mul();
    cyc_t t[$];
    obs_t m, s;
    m = exp_ex(1, MUL, 4'd2, 4'd5);
    s = exp_ex(1, SUB, 4'd2, 4'd6);
    t.push_back(mk(1, MUL, 4'd1, 4'd2, 4'd5, 0, 0, m));
    t.push_back(mk(1, SUB, 4'd1, 4'd2, 4'd6, 0, 1, m));
    t.push_back(mk(1, SUB, 4'd1, 4'd2, 4'd6, 0, 1, m));
    t.push_back(mk(1, SUB, 4'd1, 4'd2, 4'd6, 0, 0, s));
    // Single-cycle MUL instance: SUB follows immediately, never stalls.
    t[1].st_b = 1'b0; t[1].e_b = s;
    t[2].st_b = 1'b0; t[2].e_b = s;
    foreach (t[i]) begin
      drive(t[i]); sb_a.push_back(t[i].e); sb_b.push_back(t[i].e_b);
      checks++; if (ifa.stall !== t[i].st) begin errors++; $display("FAIL mul_stall[%0d] got %b exp %b", i, ifa.stall, t[i].st); end
      checks++; if (ifb.stall !== t[i].st_b) begin errors++; $display("FAIL mul1_stall[%0d] got %b exp %b", i, ifb.stall, t[i].st_b); end
      tick(); got = sb_a.pop_front();
      checks++; if (obs_a !== got) begin errors++; $display("FAIL mul_ex[%0d] got %h exp %h", i, obs_a, got); end
      got = sb_b.pop_front();
      checks++; if (obs_b !== got) begin errors++; $display("FAIL mul1_ex[%0d] got %h exp %h", i, obs_b, got); end
    end
  endtask

  task automatic test_branch();
    cyc_t t[$];
    t.push_back(mk(1, BEQ, 4'd1, 4'd2, 4'd0, 0, 0, exp_ex(1, BEQ, 4'd2, 4'd0)));
    t.push_back(mk(1, LW,  4'd1, 4'd3, 4'd0, 1, 0, '0));
    t.push_back(mk(1, ADD, 4'd1, 4'd2, 4'd4, 1, 0, exp_ex(1, ADD, 4'd2, 4'd4)));
    t.push_back(mk(1, SUB, 4'd1, 4'd2, 4'd5, 1, 0, exp_ex(1, SUB, 4'd2, 4'd5)));
    // Taken BEQ in EX while ID reads the BEQ's write address.
    t.push_back(mk(1, BEQ, 4'd1, 4'd3, 4'd0, 0, 0, exp_ex(1, BEQ, 4'd3, 4'd0)));
    t.push_back(mk(1, ADD, 4'd3, 4'd3, 4'd6, 1, 0, '0));
    t.push_back(mk(1, ADD, 4'd3, 4'd3, 4'd6, 0, 0, exp_ex(1, ADD, 4'd3, 4'd6)));
    foreach (t[i]) begin
      drive(t[i]); sb_a.push_back(t[i].e);
      checks++; if (ifa.stall !== t[i].st) begin errors++; $display("FAIL br_stall[%0d] got %b exp %b", i, ifa.stall, t[i].st); end
      tick(); got = sb_a.pop_front();
      checks++; if (obs_a !== got) begin errors++; $display("FAIL br_ex[%0d] got %h exp %h", i, obs_a, got); end
    end
  endtask

  task automatic test_illegal();
    cyc_t t[$];
    t.push_back(mk(1, 4'd12, 4'd1, 4'd2, 4'd3, 0, 0, exp_ex(1, 4'd12, 4'd2, 4'd3)));
    t.push_back(mk(0, 4'd12, 4'd1, 4'd2, 4'd3, 0, 0, '0));
    t.push_back(mk(1, 4'd11, 4'd1, 4'd2, 4'd3, 0, 0, exp_ex(1, 4'd11, 4'd2, 4'd3)));
    t.push_back(mk(1, ADD,   4'd1, 4'd2, 4'd3, 0, 0, exp_ex(1, ADD, 4'd2, 4'd3)));
    t.push_back(mk(0, 4'd15, 4'd0, 4'd0, 4'd0, 0, 0, '0));
    foreach (t[i]) begin
      drive(t[i]); sb_a.push_back(t[i].e);
      checks++; if (ifa.stall !== t[i].st) begin errors++; $display("FAIL ill_stall[%0d] got %b exp %b", i, ifa.stall, t[i].st); end
      tick(); got = sb_a.pop_front();
      checks++; if (obs_a !== got) begin errors++; $display("FAIL ill_ex[%0d] got %h exp %h", i, obs_a, got); end
    end
  endtask

  task automatic test_back_to_back();
    cyc_t t[$];
    obs_t m5, m6;
    m5 = exp_ex(1, MUL, 4'd2, 4'd5);
    m6 = exp_ex(1, MUL, 4'd2, 4'd6);
    t.push_back(mk(1, MUL, 4'd1, 4'd2, 4'd5, 0, 0, m5));
    t.push_back(mk(1, MUL, 4'd1, 4'd2, 4'd6, 0, 1, m5));
    t.push_back(mk(1, MUL, 4'd1, 4'd2, 4'd6, 0, 1, m5));
    t.push_back(mk(1, MUL, 4'd1, 4'd2, 4'd6, 0, 0, m6));
    t.push_back(mk(1, SUB, 4'd1, 4'd2, 4'd7, 0, 1, m6));
    t.push_back(mk(1, SUB, 4'd1, 4'd2, 4'd7, 0, 1, m6));
    t.push_back(mk(1, SUB, 4'd1, 4'd2, 4'd7, 0, 0, exp_ex(1, SUB, 4'd2, 4'd7)));
    // Two chained load-use pairs: LW r3; LW uses r3 -> r4; ADD uses r4.
    t.push_back(mk(1, LW,  4'd1, 4'd3, 4'd0, 0, 0, exp_ex(1, LW,  4'd3, 4'd0)));
    t.push_back(mk(1, LW,  4'd3, 4'd4, 4'd0, 0, 1, '0));
    t.push_back(mk(1, LW,  4'd3, 4'd4, 4'd0, 0, 0, exp_ex(1, LW,  4'd4, 4'd0)));
    t.push_back(mk(1, ADD, 4'd2, 4'd4, 4'd8, 0, 1, '0));
    t.push_back(mk(1, ADD, 4'd2, 4'd4, 4'd8, 0, 0, exp_ex(1, ADD, 4'd4, 4'd8)));
    foreach (t[i]) begin
      drive(t[i]); sb_a.push_back(t[i].e);
      checks++; if (ifa.stall !== t[i].st) begin errors++; $display("FAIL b2b_stall[%0d] got %b exp %b", i, ifa.stall, t[i].st); end
      tick(); got = sb_a.pop_front();
      checks++; if (obs_a !== got) begin errors++; $display("FAIL b2b_ex[%0d] got %h exp %h", i, obs_a, got); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mul();
    test_branch();
    test_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Decode-stage control unit for the pipelined datapath: decodes the 4-bit opcode into the ALU/memory/writeback control bundle and registers it into the ID/EX boundary.
- Adds hazard logic: load-use stall with bubble insertion, multi-cycle MUL hold, branch-taken flush, and an explicit illegal-opcode default (NOP plus flag).
- Sits between the IF/ID register and the execute stage; its stall output freezes the PC and IF/ID.

Parameters:
- RA_W, 4, register-address width.
- MUL_LAT, 3, execute-stage cycles for MUL, ≥1.
- ZERO_REG, 1, when 1 register 0 is hardwired and never causes a hazard.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_op_code  in  4  opcode. ADD=0, SUB=1, AND=2, XOR=3, COM=4, MUL=5, SLL=6, SRL=7, LW=8, SW=9, BEQ=10; 11–15 illegal.
- id_rs, id_rt, id_rd  in  RA_W  source and destination fields.
- ex_branch_taken  in  1  EX comparison result for the instruction currently in EX.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  out  1  EX holds a real instruction.
- ex_alu_op  out  3  ALU operation.
- ex_alu_src, ex_reg_wen, ex_reg_dst, ex_mem_ren, ex_mem_wen, ex_mem_to_reg, ex_branch  out  1 each  control bundle.
- ex_wr_addr  out  RA_W  destination: ex_reg_dst ? rt : rd.
- ex_illegal  out  1  one-cycle pulse: an illegal opcode was squashed.

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs 0, mul_cnt 0. Therefore stall=0. Reset mid-MUL or mid-stall aborts immediately; no residual stall after release.
- Decode (combinational):
  - ADD/SUB/AND/XOR/COM/MUL: alu_op=op[2:0], alu_src=0, reg_wen=1, reg_dst=0, mem_to_reg=1.
  - SLL/SRL: as above but alu_src=1.
  - LW: alu_op=ADD, alu_src=1, reg_wen=1, reg_dst=1, mem_ren=1, mem_to_reg=0.
  - SW: alu_op=ADD, alu_src=1, reg_dst=1, mem_wen=1, mem_to_reg=1.
  - BEQ: alu_op=SUB, reg_dst=1, mem_to_reg=1, branch=1.
  - Illegal opcodes: all-zero bundle.
- Source usage:
  - uses_rs for every legal opcode.
  - uses_rt for ADD, SUB, AND, XOR, MUL, SW, BEQ. COM, SLL and SRL use rs only.
- Internal conditions:
  - flush = ex_valid & ex_branch & ex_branch_taken.
  - mul_busy = (mul_cnt != 0).
  - load_use = id_valid & ex_valid & ex_mem_ren & (ex_wr_addr matches a used source). With ZERO_REG=1, address 0 never matches.
- Per-edge priority:
  1. mul_busy: EX register holds its value; mul_cnt decrements; stall=1.
  2. flush: EX loads a bubble (all zeros); the ID instruction is discarded; stall=0.
  3. load_use: EX loads a bubble; stall=1 for exactly one cycle.
  4. Otherwise: EX loads the decoded bundle with ex_valid=id_valid & legal.
     - If MUL issues, mul_cnt ← MUL_LAT−1 (MUL_LAT=1: no stall).
     - If illegal & id_valid, ex_illegal=1 for one cycle (else 0).
- stall = mul_busy | (load_use & ~flush). Combinational from current state and ID inputs.
- Timing: decode-to-EX latency is 1 cycle. MUL occupies EX for MUL_LAT cycles, with stall high for MUL_LAT−1 cycles.
- mul_cnt width is clog2(MUL_LAT)+1. It never underflows; it reloads only on MUL issue.
- ex_branch_taken is ignored unless EX holds a valid BEQ.
- Back-to-back MULs: the second issues on the cycle mul_cnt reaches 0, giving no gap cycles beyond the hold.
- Two consecutive load-use pairs each stall exactly once.

Test Plan:
- Reset: assert rst_n=0 mid-MUL with mul_cnt=2 → all outputs 0 immediately; stall=0 after release. Next ADD issues → ex_alu_op=0, ex_reg_wen=1.
- Load-use: LW rt=3, then ADD rs=3 → stall=1 for one cycle, one bubble (ex_valid=0), then ADD in EX. Repeat with rt=0 and ZERO_REG=1 → no stall.
- MUL: MUL_LAT=3, issue MUL then SUB → stall high for 2 cycles, ex_alu_op=5 held 3 cycles, SUB enters EX on the 4th. MUL_LAT=1 → no stall.
- Branch: BEQ in EX with ex_branch_taken=1 while ID holds LW → next EX is a bubble, stall=0, no ex_mem_ren. With ex_branch_taken=1 but EX holding an ADD → no flush.
- Flush beats load-use: LW in EX is not possible together with a BEQ in EX, so use BEQ taken in EX plus an ID hazard on its write addr → bubble, stall=0.
- Illegal: opcode 12, id_valid=1 → ex_valid=0, all controls 0, ex_illegal single-cycle pulse. Opcode 12 with id_valid=0 → no pulse.
